// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR     : word presented to decode when no instruction is buffered
//   INST_BYTES    : PC increment per fetched instruction
//   fetch_state_t : memory-side FSM states
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write an entry (ignored when full)
//   pop           : remove the head entry (ignored when empty)
//   flush         : empty the buffer; overrides push and pop
//   rdata         : head entry (meaningful only when !empty)
//   count/empty/full : occupancy
module fetch_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              push_en;
  logic              pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to
// instruction memory (req/ack) and buffers fetched words for decode.
//   clk, rst              : clock, synchronous active-high reset
//   imem_req/addr         : request to memory, address held until ack
//   imem_ack/rdata        : completion and returned word
//   redirect/redirect_pc  : flush buffered/in-flight fetches, restart at new PC
//   inst_valid/instruction/inst_pc/inst_ready : valid/ready output to decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  output logic [31:0]      instruction,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready
);

  localparam int unsigned      CntW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned      DataW     = WIDTH + 32;
  localparam logic [WIDTH-1:0] AlignMask = ~WIDTH'(3);

  fetch_state_t     state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] target_q;   // redirect target held while draining a stale request
  logic [WIDTH-1:0] redirect_aligned;

  logic             push_eff;
  logic             pop_eff;
  logic             fill_to_full;
  logic [DataW-1:0] fifo_head;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  assign redirect_aligned = redirect_pc & AlignMask;

  // A redirect discards both the returning word and any pop this cycle.
  assign push_eff = (state_q == REQ) && imem_ack && !redirect;
  assign pop_eff  = inst_valid && inst_ready && !redirect;

  // Post-push occupancy reaches FIFO_DEPTH only if nothing leaves this cycle.
  assign fill_to_full = push_eff && !pop_eff && (fifo_count == CntW'(FIFO_DEPTH - 1));

  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DataW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_eff),
    .wdata ({pc_q, imem_rdata}),
    .pop   (pop_eff),
    .flush (redirect),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC & AlignMask;
      target_q <= RESET_PC & AlignMask;
    end else if (redirect) begin
      if ((state_q == REQ || state_q == DROP) && !imem_ack) begin
        // Request still outstanding: let it finish, then jump.
        target_q <= redirect_aligned;
        state_q  <= DROP;
      end else begin
        pc_q    <= redirect_aligned;
        state_q <= REQ;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_full) state_q <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            pc_q <= pc_q + WIDTH'(INST_BYTES);
            if (fill_to_full) state_q <= IDLE;
          end
        end
        DROP: begin
          if (imem_ack) begin
            pc_q    <= target_q;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = pc_q;
  assign inst_valid  = !fifo_empty;
  assign instruction = inst_valid ? fifo_head[31:0] : NOP_INSTR;
  assign inst_pc     = inst_valid ? fifo_head[DataW-1:32] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // Second instance: reset PC near the top of the address space, zero-wait memory.
  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;

  int n_checks = 0;
  int n_errors = 0;
  int mem_delay = 0;
  int wait_cnt = 0;
  int ack_cnt = 0;
  logic seen_pc8 = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  fetch_unit #(
    .WIDTH      (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .instruction (instruction),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  fetch_unit #(
    .WIDTH      (32),
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (2)
  ) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_ack    (req2),
    .imem_rdata  (inst_of(addr2)),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .inst_valid  (valid2),
    .instruction (instr2),
    .inst_pc     (pc2),
    .inst_ready  (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after mem_delay wait cycles of an asserted request.
  assign imem_ack   = imem_req && (wait_cnt == mem_delay);
  assign imem_rdata = inst_of(imem_addr);

  always @(posedge clk) begin
    if (!rst && imem_req && imem_ack) ack_cnt = ack_cnt + 1;
    if (imem_req && !imem_ack) wait_cnt = wait_cnt + 1;
    else wait_cnt = 0;
  end

  always @(negedge clk) begin
    if (inst_valid && inst_pc == 32'h8) seen_pc8 = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    step();
    step();
    rst      = 1'b0;
    ack_cnt  = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b1;
    mem_delay   = 0;

    // Reset state and straight-line zero-wait fetch.
    step();
    step();
    check("rst_req",   64'(imem_req),    64'(0));
    check("rst_addr",  64'(imem_addr),   64'h0);
    check("rst_valid", 64'(inst_valid),  64'(0));
    check("rst_instr", 64'(instruction), 64'h13);
    check("rst_pc",    64'(inst_pc),     64'h0);
    check("rst_addr2", 64'(addr2),       64'hFFFF_FFF8);
    rst = 1'b0;
    step();
    check("t1_req",    64'(imem_req),   64'(1));
    check("t1_addr0",  64'(imem_addr),  64'h0);
    check("t1_nvalid", 64'(inst_valid), 64'(0));
    step();
    check("t1_valid",  64'(inst_valid),  64'(1));
    check("t1_pc0",    64'(inst_pc),     64'h0);
    check("t1_instr0", 64'(instruction), 64'(inst_of(32'h0)));
    check("t1_addr4",  64'(imem_addr),   64'h4);
    check("wrap_pc0",  64'(pc2),         64'hFFFF_FFF8);
    step();
    check("t1_pc4",    64'(inst_pc),   64'h4);
    check("t1_addr8",  64'(imem_addr), 64'h8);
    check("wrap_pc1",  64'(pc2),       64'hFFFF_FFFC);
    step();
    check("t1_pc8",    64'(inst_pc),     64'h8);
    check("t1_instr8", 64'(instruction), 64'(inst_of(32'h8)));
    check("wrap_pc2",  64'(pc2),         64'h0);

    // Back-pressure: buffer fills with two words, then fetch stalls.
    inst_ready = 1'b0;
    do_reset();
    repeat (10) step();
    check("t2_acks",   64'(ack_cnt),    64'(2));
    check("t2_req",    64'(imem_req),   64'(0));
    check("t2_valid",  64'(inst_valid), 64'(1));
    check("t2_pc0",    64'(inst_pc),    64'h0);
    inst_ready = 1'b1;
    step();
    check("t2_pc4",    64'(inst_pc),     64'h4);
    check("t2_instr4", 64'(instruction), 64'(inst_of(32'h4)));
    check("t2_idle",   64'(imem_req),    64'(0));
    step();
    check("t2_req8",   64'(imem_req),   64'(1));
    check("t2_addr8",  64'(imem_addr),  64'h8);
    check("t2_empty",  64'(inst_valid), 64'(0));
    step();
    check("t2_pc8",    64'(inst_pc), 64'h8);

    // Three wait cycles: request and address held, single push.
    mem_delay = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hreq",  64'(imem_req),   64'(1));
      check("t3_haddr", 64'(imem_addr),  64'h0);
      check("t3_nval",  64'(inst_valid), 64'(0));
    end
    step();
    check("t3_ack",   64'(imem_ack), 64'(1));
    step();
    check("t3_valid", 64'(inst_valid), 64'(1));
    check("t3_pc0",   64'(inst_pc),    64'h0);
    check("t3_addr4", 64'(imem_addr),  64'h4);
    check("t3_acks",  64'(ack_cnt),    64'(1));
    step();
    check("t3_nodup", 64'(inst_valid), 64'(0));

    // Redirect while the request to 0x8 is waiting for its ack.
    mem_delay = 0;
    do_reset();
    step();
    step();
    step();
    mem_delay   = 3;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    seen_pc8    = 1'b0;
    step();
    redirect = 1'b0;
    check("t4_flush", 64'(inst_valid), 64'(0));
    check("t4_hold0", 64'(imem_addr),  64'h8);
    step();
    check("t4_hold1", 64'(imem_addr), 64'h8);
    step();
    check("t4_hold2", 64'(imem_addr), 64'h8);
    check("t4_hreq",  64'(imem_req),  64'(1));
    step();
    mem_delay = 0;
    check("t4_addr",  64'(imem_addr),  64'h100);
    check("t4_drop",  64'(inst_valid), 64'(0));
    step();
    check("t4_pc",    64'(inst_pc),     64'h100);
    check("t4_instr", 64'(instruction), 64'(inst_of(32'h100)));
    step();
    check("t4_pc104", 64'(inst_pc), 64'h104);
    check("t4_no8",   64'(seen_pc8), 64'(0));

    // Unaligned redirect coincident with the ack that would fill the buffer.
    inst_ready = 1'b0;
    do_reset();
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    check("t5_flush", 64'(inst_valid), 64'(0));
    check("t5_addr",  64'(imem_addr),  64'h200);
    check("t5_req",   64'(imem_req),   64'(1));
    inst_ready = 1'b1;
    step();
    check("t5_pc",    64'(inst_pc), 64'h200);

    // Redirect from IDLE with a full buffer.
    inst_ready = 1'b0;
    do_reset();
    repeat (4) step();
    check("t6_full",  64'(imem_req), 64'(0));
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("t6_flush", 64'(inst_valid), 64'(0));
    check("t6_addr",  64'(imem_addr),  64'h40);
    check("t6_req",   64'(imem_req),   64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
